// File: rtl/noise_injector_if.sv
// Pixel stream bundle for noise_injector: upstream valid/ready/pixel and
// downstream valid/ready/pixel plus the noisy flag.
interface noise_injector_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_pixel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_pixel;
  logic       out_noisy;

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_pixel, out_noisy
  );

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_pixel, out_noisy
  );
endinterface

// File: rtl/noise_injector.sv
// Salt-and-pepper noise injector: single registered stage that replaces a
// pixel with 8'h00/8'hFF with probability density/256, driven by a Galois LFSR.
module noise_injector #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [7:0]        density,
  input  logic              seed_load,
  input  logic [15:0]       seed,
  input  logic              cnt_clr,
  noise_injector_if.slave   pix,
  output logic [15:0]       noise_count
);

  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic        out_valid_q;
  logic [7:0]  out_pixel_q;
  logic        out_noisy_q;
  logic        in_ready_c;
  logic        accept;
  logic        emit;
  logic        noisy;
  logic [7:0]  pixel_d;

  assign in_ready_c    = !out_valid_q || pix.out_ready;
  assign accept        = pix.in_valid && in_ready_c;
  assign emit          = out_valid_q && pix.out_ready;
  assign pix.in_ready  = in_ready_c;
  assign pix.out_valid = out_valid_q;
  assign pix.out_pixel = out_pixel_q;
  assign pix.out_noisy = out_noisy_q;

  always_comb begin
    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    noisy     = en && (lfsr[7:0] < density);
    pixel_d   = pix.in_pixel;
    if (noisy) pixel_d = lfsr[8] ? 8'hFF : 8'h00;
  end

  // A seed load replaces the advance; the accepted pixel already used the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else if (seed_load) begin
      lfsr <= (seed == '0) ? SEED : seed;
    end else if (accept) begin
      lfsr <= lfsr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_noisy_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_pixel_q <= pixel_d;
      out_noisy_q <= noisy;
    end else if (emit) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      noise_count <= '0;
    end else if (cnt_clr) begin
      noise_count <= '0;
    end else if (accept && noisy && (noise_count != '1)) begin
      noise_count <= noise_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_noise_injector.sv
// Directed self-checking bench for noise_injector.
module tb_noise_injector;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  density = '0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = '0;
  logic        cnt_clr = 1'b0;
  logic [15:0] noise_count;
  int unsigned checks = 0;
  int unsigned errors = 0;

  noise_injector_if pix ();

  noise_injector #(.SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .density(density),
    .seed_load(seed_load), .seed(seed), .cnt_clr(cnt_clr),
    .pix(pix), .noise_count(noise_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    pix.in_valid = 1'b0; pix.in_pixel = '0; pix.out_ready = 1'b1;
    seed_load = 1'b0; cnt_clr = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    pix.in_valid = 1'b0; pix.in_pixel = '0; pix.out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++; if (pix.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", pix.out_valid); end
    checks++; if (pix.out_pixel !== 8'h00) begin errors++; $display("FAIL rst_pixel: got %h want 00", pix.out_pixel); end
    checks++; if (pix.out_noisy !== 1'b0) begin errors++; $display("FAIL rst_noisy: got %b want 0", pix.out_noisy); end
    checks++; if (noise_count !== 16'h0000) begin errors++; $display("FAIL rst_count: got %h want 0000", noise_count); end
    checks++; if (pix.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", pix.in_ready); end
    checks++; if (dut.lfsr !== 16'hACE1) begin errors++; $display("FAIL rst_lfsr: got %h want ace1", dut.lfsr); end
    rst_n = 1'b1;
  endtask

  task automatic test_passthrough();
    logic [7:0] vals [3];
    vals = '{8'h10, 8'h20, 8'h30};
    en = 1'b1; density = 8'd0; pix.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pix.in_valid = 1'b1; pix.in_pixel = vals[i];
      tick();
      checks++; if (pix.out_valid !== 1'b1) begin errors++; $display("FAIL pt_valid%0d: got %b want 1", i, pix.out_valid); end
      checks++; if (pix.out_pixel !== vals[i]) begin errors++; $display("FAIL pt_pixel%0d: got %h want %h", i, pix.out_pixel, vals[i]); end
      checks++; if (pix.out_noisy !== 1'b0) begin errors++; $display("FAIL pt_noisy%0d: got %b want 0", i, pix.out_noisy); end
    end
    pix.in_valid = 1'b0;
    tick();
    checks++; if (pix.out_valid !== 1'b0) begin errors++; $display("FAIL pt_drain: got %b want 0", pix.out_valid); end
    checks++; if (noise_count !== 16'h0000) begin errors++; $display("FAIL pt_count: got %h want 0000", noise_count); end
    // three accepts from ACE1 -> E270 -> 7138 -> 389C
    checks++; if (dut.lfsr !== 16'h389C) begin errors++; $display("FAIL pt_lfsr: got %h want 389c", dut.lfsr); end
  endtask

  task automatic test_full_density();
    apply_reset();
    en = 1'b1; density = 8'd255; pix.out_ready = 1'b1;
    pix.in_valid = 1'b1; pix.in_pixel = 8'h55;
    tick();
    checks++; if (pix.out_pixel !== 8'h00) begin errors++; $display("FAIL fd_pix0: got %h want 00", pix.out_pixel); end
    checks++; if (pix.out_noisy !== 1'b1) begin errors++; $display("FAIL fd_noisy0: got %b want 1", pix.out_noisy); end
    checks++; if (dut.lfsr !== 16'hE270) begin errors++; $display("FAIL fd_lfsr0: got %h want e270", dut.lfsr); end
    pix.in_pixel = 8'h66;
    tick();
    checks++; if (pix.out_pixel !== 8'h00) begin errors++; $display("FAIL fd_pix1: got %h want 00", pix.out_pixel); end
    checks++; if (pix.out_noisy !== 1'b1) begin errors++; $display("FAIL fd_noisy1: got %b want 1", pix.out_noisy); end
    checks++; if (dut.lfsr !== 16'h7138) begin errors++; $display("FAIL fd_lfsr1: got %h want 7138", dut.lfsr); end
    checks++; if (noise_count !== 16'd2) begin errors++; $display("FAIL fd_count: got %0d want 2", noise_count); end
    pix.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    // L = 7138: r = 38, pol = 1 -> FF
    int unsigned emits = 0;
    pix.out_ready = 1'b0; pix.in_valid = 1'b1; pix.in_pixel = 8'h77;
    tick();
    checks++; if (pix.out_pixel !== 8'hFF) begin errors++; $display("FAIL bp_pix: got %h want ff", pix.out_pixel); end
    checks++; if (noise_count !== 16'd3) begin errors++; $display("FAIL bp_count: got %0d want 3", noise_count); end
    pix.in_pixel = 8'h88;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (pix.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d: got %b want 0", i, pix.in_ready); end
      checks++; if ({pix.out_valid, pix.out_pixel, pix.out_noisy} !== {1'b1, 8'hFF, 1'b1}) begin
        errors++; $display("FAIL bp_hold%0d: got %b/%h/%b want 1/ff/1", i, pix.out_valid, pix.out_pixel, pix.out_noisy); end
      checks++; if (dut.lfsr !== 16'h389C) begin errors++; $display("FAIL bp_lfsr%0d: got %h want 389c", i, dut.lfsr); end
    end
    pix.in_valid = 1'b0; pix.out_ready = 1'b1;
    #1;
    checks++; if (pix.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_release: got %b want 1", pix.in_ready); end
    for (int i = 0; i < 3; i++) begin
      if (pix.out_valid && pix.out_ready) emits++;
      tick();
    end
    checks++; if (emits !== 1) begin errors++; $display("FAIL bp_emits: got %0d want 1", emits); end
  endtask

  task automatic test_seed();
    seed_load = 1'b1; seed = 16'h0000; pix.in_valid = 1'b0;
    tick();
    checks++; if (dut.lfsr !== 16'hACE1) begin errors++; $display("FAIL sd_zero: got %h want ace1", dut.lfsr); end
    // old L = ACE1 (r = E1 < E2) injects; new seed 12F0 (r = F0) would not
    en = 1'b1; density = 8'hE2;
    seed = 16'h12F0; pix.in_valid = 1'b1; pix.in_pixel = 8'h99;
    tick();
    seed_load = 1'b0; pix.in_valid = 1'b0;
    checks++; if (pix.out_pixel !== 8'h00) begin errors++; $display("FAIL sd_pix: got %h want 00", pix.out_pixel); end
    checks++; if (pix.out_noisy !== 1'b1) begin errors++; $display("FAIL sd_noisy: got %b want 1", pix.out_noisy); end
    checks++; if (dut.lfsr !== 16'h12F0) begin errors++; $display("FAIL sd_lfsr: got %h want 12f0", dut.lfsr); end
    checks++; if (noise_count !== 16'd4) begin errors++; $display("FAIL sd_count: got %0d want 4", noise_count); end
    tick();
  endtask

  task automatic test_en_off();
    en = 1'b0; density = 8'd255; pix.in_valid = 1'b1; pix.in_pixel = 8'hAB;
    tick();
    pix.in_valid = 1'b0;
    checks++; if (pix.out_pixel !== 8'hAB) begin errors++; $display("FAIL en_pix: got %h want ab", pix.out_pixel); end
    checks++; if (pix.out_noisy !== 1'b0) begin errors++; $display("FAIL en_noisy: got %b want 0", pix.out_noisy); end
    checks++; if (dut.lfsr !== 16'h0978) begin errors++; $display("FAIL en_lfsr: got %h want 0978", dut.lfsr); end
    checks++; if (noise_count !== 16'd4) begin errors++; $display("FAIL en_count: got %0d want 4", noise_count); end
    tick();
  endtask

  task automatic test_counter();
    logic [15:0] ml;
    logic [15:0] mc;
    apply_reset();
    ml = 16'hACE1; mc = '0;
    en = 1'b1; density = 8'd255; pix.out_ready = 1'b1;
    pix.in_valid = 1'b1; pix.in_pixel = 8'h5A;
    for (int i = 0; i < 66000; i++) begin
      if (ml[7:0] != 8'hFF && mc != 16'hFFFF) mc = mc + 16'd1;
      ml = lfsr_step(ml);
      tick();
    end
    checks++; if (noise_count !== mc) begin errors++; $display("FAIL ct_model: got %h want %h", noise_count, mc); end
    checks++; if (noise_count !== 16'hFFFF) begin errors++; $display("FAIL ct_sat: got %h want ffff", noise_count); end
    checks++; if (dut.lfsr !== ml) begin errors++; $display("FAIL ct_lfsr: got %h want %h", dut.lfsr, ml); end
    for (int i = 0; i < 4 && ml[7:0] == 8'hFF; i++) begin
      ml = lfsr_step(ml);
      tick();
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0; pix.in_valid = 1'b0;
    checks++; if (pix.out_noisy !== 1'b1) begin errors++; $display("FAIL ct_clr_noisy: got %b want 1", pix.out_noisy); end
    checks++; if (noise_count !== 16'h0000) begin errors++; $display("FAIL ct_clr: got %h want 0000", noise_count); end
    tick();
  endtask

  task automatic test_reset_abort();
    int unsigned emits = 0;
    en = 1'b0; pix.out_ready = 1'b0; pix.in_valid = 1'b1; pix.in_pixel = 8'h3C;
    tick();
    pix.in_valid = 1'b0;
    checks++; if (pix.out_valid !== 1'b1) begin errors++; $display("FAIL ra_pending: got %b want 1", pix.out_valid); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (pix.out_valid !== 1'b0) begin errors++; $display("FAIL ra_valid: got %b want 0", pix.out_valid); end
    checks++; if (pix.out_pixel !== 8'h00) begin errors++; $display("FAIL ra_pixel: got %h want 00", pix.out_pixel); end
    checks++; if (dut.lfsr !== 16'hACE1) begin errors++; $display("FAIL ra_lfsr: got %h want ace1", dut.lfsr); end
    pix.out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (pix.out_valid && pix.out_ready) emits++;
      tick();
    end
    checks++; if (emits !== 0) begin errors++; $display("FAIL ra_emits: got %0d want 0", emits); end
    pix.in_valid = 1'b1; pix.in_pixel = 8'hC3;
    tick();
    pix.in_valid = 1'b0;
    checks++; if ({pix.out_valid, pix.out_pixel} !== {1'b1, 8'hC3}) begin
      errors++; $display("FAIL ra_resume: got %b/%h want 1/c3", pix.out_valid, pix.out_pixel); end
    tick();
  endtask

  initial begin
    pix.in_valid = 1'b0; pix.in_pixel = '0; pix.out_ready = 1'b0;
    test_reset();
    test_passthrough();
    test_full_density();
    test_backpressure();
    test_seed();
    test_en_off();
    test_counter();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
